sm_mult_seq: RTL and testbench

- Iterative shift-add multiplier for sign-magnitude fixed-point operands, parametrised in word width and fractional bits.
- Produces a saturated result of the same format, with valid/ready handshakes on both input and output.
- Serves as the area-lean multiplier for the IIR datapath, where coefficient products are not needed every cycle.
- Adds over the combinational multiplier: multi-cycle operation, backpressure, an overflow flag, negative-zero normalisation and optional rounding.

---
 rtl/sm_mult_seq.sv | 86 ++++++++
 tb/tb_sm_mult_seq.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/sm_mult_seq.sv
// sm_mult_seq: iterative sign-magnitude shift-add multiplier, saturating; SM_MULT_SEQ_ROUND_EN enables round-half-up of the magnitude
module sm_mult_seq #(
  parameter int WIDTH = 16,
  parameter int FRAC  = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             overflow
);
  localparam int M  = WIDTH - 1;
  localparam int AW = 2 * M;
  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(M - 1);
  localparam logic [AW:0] MAXMAG = {{(AW + 1 - M){1'b0}}, {M{1'b1}}};
`ifdef SM_MULT_SEQ_ROUND_EN
  localparam logic [AW:0] RND = (FRAC > 0) ? ((AW + 1)'(1) << ((FRAC > 0) ? FRAC - 1 : 0)) : '0;
`else
  localparam logic [AW:0] RND = '0;
`endif
  typedef enum logic [1:0] {IDLE, CALC, NORM, DONE} state_t;
  state_t        r_state, w_next;
  logic [AW-1:0] r_mcand, r_acc;
  logic [M-1:0]  r_mult;
  logic [CW-1:0] r_cnt;
  logic          r_sign;
  logic [AW:0]   w_shift;
  logic          w_ovf;
  logic [M-1:0]  w_mag;
  assign in_ready  = r_state == IDLE;
  assign out_valid = r_state == DONE;
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE: w_next = in_valid ? CALC : IDLE;
      CALC: w_next = (r_cnt == LAST) ? NORM : CALC;
      NORM: w_next = DONE;
      DONE: w_next = out_ready ? IDLE : DONE;
      default: w_next = IDLE;
    endcase
  end
  always_comb begin
    w_shift = ({1'b0, r_acc} + RND) >> FRAC;
    w_ovf   = w_shift > MAXMAG;
    w_mag   = w_ovf ? '1 : w_shift[M-1:0];
  end
  always_ff @(posedge clk) r_state <= rst ? IDLE : w_next;
  always_ff @(posedge clk) begin
    if (rst) begin
      r_mcand  <= '0;
      r_mult   <= '0;
      r_sign   <= 1'b0;
      r_acc    <= '0;
      r_cnt    <= '0;
      result   <= '0;
      overflow <= 1'b0;
    end else begin
      case (r_state)
        IDLE: if (in_valid) begin
          r_mcand <= AW'(a[M-1:0]);
          r_mult  <= b[M-1:0];
          r_sign  <= a[M] ^ b[M];
          r_acc   <= '0;
          r_cnt   <= '0;
        end
        CALC: begin
          if (r_mult[0]) r_acc <= r_acc + r_mcand;
          r_mcand <= r_mcand << 1;
          r_mult  <= r_mult >> 1;
          r_cnt   <= r_cnt + CW'(1);
        end
        NORM: begin
          result   <= {r_sign & (|w_mag), w_mag};
          overflow <= w_ovf;
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_sm_mult_seq.sv
// tb_sm_mult_seq: directed self-checking bench for sm_mult_seq at default parameters
module tb_sm_mult_seq;
  logic clk = 1'b0, rst = 1'b1, in_valid = 1'b0, out_ready = 1'b0;
  logic [15:0] a = '0, b = '0;
  logic in_ready, out_valid, overflow;
  logic [15:0] result;
  int pass = 0, total = 0;

  sm_mult_seq dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .a(a), .b(b),
    .out_valid(out_valid), .out_ready(out_ready), .result(result), .overflow(overflow)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drives one accepted operation from IDLE and waits (bounded) for out_valid; leaves the DUT in DONE.
  task automatic start_op(input logic [15:0] x, input logic [15:0] y, output int lat);
    a = x; b = y; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 40) begin tick(); lat++; end
  endtask

  task automatic release_done();
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick(); tick();
    rst = 1'b0;
    total++; if (in_ready !== 1'b1) $display("FAIL reset_in_ready got %b want 1", in_ready); else pass++;
    total++; if (out_valid !== 1'b0) $display("FAIL reset_out_valid got %b want 0", out_valid); else pass++;
    total++; if (result !== 16'h0000) $display("FAIL reset_result got %h want 0000", result); else pass++;
    total++; if (overflow !== 1'b0) $display("FAIL reset_overflow got %b want 0", overflow); else pass++;
  endtask

  task automatic test_basic();
    int lat;
    start_op(16'h0180, 16'h0340, lat);
    total++; if (lat !== 16) $display("FAIL basic_latency got %0d want 16", lat); else pass++;
    total++; if (result !== 16'h04E0) $display("FAIL basic_result got %h want 04e0", result); else pass++;
    total++; if (overflow !== 1'b0) $display("FAIL basic_overflow got %b want 0", overflow); else pass++;
    total++; if (in_ready !== 1'b0) $display("FAIL basic_in_ready_done got %b want 0", in_ready); else pass++;
    release_done();
    total++; if (in_ready !== 1'b1 || out_valid !== 1'b0) $display("FAIL basic_return_idle got rdy=%b vld=%b want rdy=1 vld=0", in_ready, out_valid); else pass++;
    total++; if (result !== 16'h04E0) $display("FAIL basic_result_hold got %h want 04e0", result); else pass++;
  endtask

  task automatic test_signs();
    logic [15:0] va [3] = '{16'h8180, 16'h0180, 16'h8180};
    logic [15:0] vb [3] = '{16'h0340, 16'h8340, 16'h8340};
    logic [15:0] ve [3] = '{16'h84E0, 16'h84E0, 16'h04E0};
    int lat;
    for (int i = 0; i < 3; i++) begin
      start_op(va[i], vb[i], lat);
      total++; if (result !== ve[i] || lat !== 16) $display("FAIL sign_%0d got %h lat %0d want %h lat 16", i, result, lat, ve[i]); else pass++;
      release_done();
    end
  endtask

  task automatic test_saturation();
    int lat;
    start_op(16'hFF80, 16'hFF40, lat);
    total++; if (result !== 16'h7FFF) $display("FAIL sat_result got %h want 7fff", result); else pass++;
    total++; if (overflow !== 1'b1) $display("FAIL sat_overflow got %b want 1", overflow); else pass++;
    release_done();
    start_op(16'h8180, 16'h0340, lat);
    total++; if (overflow !== 1'b0 || result !== 16'h84E0) $display("FAIL sat_clear got %h ovf %b want 84e0 ovf 0", result, overflow); else pass++;
    release_done();
  endtask

  task automatic test_zero();
    int lat;
    start_op(16'h8000, 16'h0123, lat);
    total++; if (result !== 16'h0000 || overflow !== 1'b0) $display("FAIL negzero_a got %h ovf %b want 0000 ovf 0", result, overflow); else pass++;
    total++; if (lat !== 16) $display("FAIL zero_latency got %0d want 16", lat); else pass++;
    release_done();
    start_op(16'h8180, 16'h8000, lat);
    total++; if (result !== 16'h0000) $display("FAIL negzero_b got %h want 0000", result); else pass++;
    release_done();
  endtask

  task automatic test_rounding();
    int lat;
    logic [15:0] exp_r;
`ifdef SM_MULT_SEQ_ROUND_EN
    exp_r = 16'h0001;
`else
    exp_r = 16'h0000;
`endif
    start_op(16'h0001, 16'h0080, lat);
    total++; if (result !== exp_r) $display("FAIL round_half got %h want %h", result, exp_r); else pass++;
    release_done();
    // Negative tiny product that truncates to zero must not keep its sign.
`ifdef SM_MULT_SEQ_ROUND_EN
    exp_r = 16'h0000;
`else
    exp_r = 16'h0000;
`endif
    start_op(16'h8001, 16'h007F, lat);
    total++; if (result !== exp_r) $display("FAIL round_below_half got %h want %h", result, exp_r); else pass++;
    release_done();
  endtask

  task automatic test_backpressure();
    int lat;
    start_op(16'hFF80, 16'hFF40, lat);
    for (int i = 0; i < 5; i++) begin
      total++;
      if (out_valid !== 1'b1 || in_ready !== 1'b0 || result !== 16'h7FFF || overflow !== 1'b1)
        $display("FAIL backpressure_%0d got vld=%b rdy=%b res=%h ovf=%b want vld=1 rdy=0 res=7fff ovf=1", i, out_valid, in_ready, result, overflow);
      else pass++;
      tick();
    end
    release_done();
    total++; if (out_valid !== 1'b0 || in_ready !== 1'b1) $display("FAIL backpressure_release got vld=%b rdy=%b want vld=0 rdy=1", out_valid, in_ready); else pass++;
  endtask

  task automatic test_busy_ignore();
    int lat;
    a = 16'h0180; b = 16'h0340; in_valid = 1'b1;
    tick();
    a = 16'h7FFF; b = 16'h7FFF;
    lat = 0;
    while (!out_valid && lat < 40) begin in_valid = lat[0]; tick(); lat++; end
    in_valid = 1'b0;
    total++; if (result !== 16'h04E0 || lat !== 16) $display("FAIL busy_ignore got %h lat %0d want 04e0 lat 16", result, lat); else pass++;
    release_done();
    start_op(16'h0200, 16'h0300, lat);
    total++; if (result !== 16'h0600) $display("FAIL busy_next got %h want 0600", result); else pass++;
    release_done();
  endtask

  task automatic test_mid_reset();
    int lat;
    a = 16'h7F00; b = 16'h0200; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    repeat (6) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    total++; if (in_ready !== 1'b1 || out_valid !== 1'b0 || result !== 16'h0000 || overflow !== 1'b0)
      $display("FAIL mid_reset got rdy=%b vld=%b res=%h ovf=%b want rdy=1 vld=0 res=0000 ovf=0", in_ready, out_valid, result, overflow);
    else pass++;
    lat = 0;
    while (!out_valid && lat < 20) begin tick(); lat++; end
    total++; if (out_valid !== 1'b0) $display("FAIL mid_reset_no_result got vld=%b want 0", out_valid); else pass++;
    start_op(16'h0180, 16'h0340, lat);
    total++; if (result !== 16'h04E0 || lat !== 16) $display("FAIL mid_reset_next got %h lat %0d want 04e0 lat 16", result, lat); else pass++;
    release_done();
  endtask

  task automatic test_back_to_back();
    int lat;
    start_op(16'h0100, 16'h0500, lat);
    total++; if (result !== 16'h0500) $display("FAIL b2b_first got %h want 0500", result); else pass++;
    // Operands offered while DONE is released must wait for the following IDLE edge.
    a = 16'h0300; b = 16'h8300; in_valid = 1'b1; out_ready = 1'b1;
    tick();
    total++; if (in_ready !== 1'b1) $display("FAIL b2b_no_accept_in_done got rdy=%b want 1", in_ready); else pass++;
    tick();
    in_valid = 1'b0;
    total++; if (in_ready !== 1'b0) $display("FAIL b2b_accept got rdy=%b want 0", in_ready); else pass++;
    lat = 0;
    while (!out_valid && lat < 40) begin tick(); lat++; end
    total++; if (result !== 16'h8900 || lat !== 16) $display("FAIL b2b_second got %h lat %0d want 8900 lat 16", result, lat); else pass++;
    tick();
    out_ready = 1'b0;
    total++; if (out_valid !== 1'b0 || in_ready !== 1'b1) $display("FAIL b2b_single_done got vld=%b rdy=%b want vld=0 rdy=1", out_valid, in_ready); else pass++;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_signs();
    test_saturation();
    test_zero();
    test_rounding();
    test_backpressure();
    test_busy_ignore();
    test_mid_reset();
    test_back_to_back();
    $display("%0d/%0d checks passed", pass, total);
    $finish;
  end
endmodule
